// File: rtl/mux_64x1_pipelined_scan.sv
// 64:1 lane selector built as three registered 4:1 levels, fed either by an
// external select request or by a free-running lane scan counter.
module mux_64x1_pipelined_scan #(
   parameter int LANE_W = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [64*LANE_W-1:0] din,
   input  logic                 sel_valid,
   input  logic [5:0]           sel,
   input  logic                 scan_en,
   input  logic                 stall,
   output logic [LANE_W-1:0]    dout,
   output logic                 dout_valid,
   output logic [5:0]           dout_idx,
   output logic                 frame_done
);

   logic [5:0]        r_scan_cnt;
   logic              w_issue_valid;
   logic [5:0]        w_issue_idx;

   logic [LANE_W-1:0] w_lanes   [64];
   logic [LANE_W-1:0] w_s1_next [16];
   logic [LANE_W-1:0] w_s2_next [4];

   logic [LANE_W-1:0] r_s1_data [16];
   logic              r_s1_valid;
   logic              r_s1_scan;
   logic [5:0]        r_s1_idx;

   logic [LANE_W-1:0] r_s2_data [4];
   logic              r_s2_valid;
   logic              r_s2_scan;
   logic [5:0]        r_s2_idx;

   logic [LANE_W-1:0] r_dout;
   logic              r_dout_valid;
   logic [5:0]        r_dout_idx;
   logic              r_frame_done;

   // Scan mode always wins; a sel_valid seen while scanning is dropped.
   assign w_issue_valid = !stall && (scan_en || sel_valid);
   assign w_issue_idx   = scan_en ? r_scan_cnt : sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan_cnt <= '0;
      end else if (!stall) begin
         r_scan_cnt <= scan_en ? r_scan_cnt + 6'd1 : 6'd0;
      end
   end

   generate
      for (genvar gi = 0; gi < 64; gi++) begin : g_lane
         assign w_lanes[gi] = din[gi*LANE_W +: LANE_W];
      end
      for (genvar gi = 0; gi < 16; gi++) begin : g_lvl1
         localparam logic [3:0] GRP = 4'(gi);
         assign w_s1_next[gi] = w_lanes[{GRP, w_issue_idx[1:0]}];
      end
      for (genvar gi = 0; gi < 4; gi++) begin : g_lvl2
         localparam logic [1:0] GRP = 2'(gi);
         assign w_s2_next[gi] = r_s1_data[{GRP, r_s1_idx[3:2]}];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_data  <= '{default: '0};
         r_s1_valid <= 1'b0;
         r_s1_scan  <= 1'b0;
         r_s1_idx   <= '0;
         r_s2_data  <= '{default: '0};
         r_s2_valid <= 1'b0;
         r_s2_scan  <= 1'b0;
         r_s2_idx   <= '0;
      end else if (!stall) begin
         r_s1_data  <= w_s1_next;
         r_s1_valid <= w_issue_valid;
         r_s1_scan  <= scan_en;
         r_s1_idx   <= w_issue_idx;
         r_s2_data  <= w_s2_next;
         r_s2_valid <= r_s1_valid;
         r_s2_scan  <= r_s1_scan;
         r_s2_idx   <= r_s1_idx;
      end
   end

   // Output data and index only move on a valid entry so they hold the last result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_dout_idx   <= '0;
         r_frame_done <= 1'b0;
      end else if (!stall) begin
         r_dout_valid <= r_s2_valid;
         r_frame_done <= r_s2_valid && r_s2_scan && (r_s2_idx == 6'd63);
         if (r_s2_valid) begin
            r_dout     <= r_s2_data[r_s2_idx[5:4]];
            r_dout_idx <= r_s2_idx;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign dout_idx   = r_dout_idx;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_mux_64x1_pipelined_scan.sv
// Scoreboard bench for the pipelined 64:1 scan mux: the driver queues expected
// outputs at issue time, a negedge monitor pops and compares them.
module tb_mux_64x1_pipelined_scan;

   localparam int LANE_W = 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [63:0]       din = '0;
   logic              sel_valid = 1'b0;
   logic [5:0]        sel = '0;
   logic              scan_en = 1'b0;
   logic              stall = 1'b0;
   logic [LANE_W-1:0] dout;
   logic              dout_valid;
   logic [5:0]        dout_idx;
   logic              frame_done;

   mux_64x1_pipelined_scan #(.LANE_W(LANE_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .sel_valid  (sel_valid),
      .sel        (sel),
      .scan_en    (scan_en),
      .stall      (stall),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_idx   (dout_idx),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [LANE_W-1:0] data;
      logic [5:0]        idx;
      logic              fd;
      int                due;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   eff_cnt  = 0;
   logic edge_stalled = 1'b0;
   logic [5:0] m_scan = '0;

   // Counts only the edges at which the pipeline actually advances.
   always @(posedge clk) begin
      edge_stalled <= stall;
      if (rst_n && !stall) eff_cnt <= eff_cnt + 1;
   end

   function automatic void chk(string nm, longint got, longint want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", nm, got, want, $time);
      end
   endfunction

   function automatic void push(logic [5:0] idx, logic is_scan, logic [LANE_W-1:0] d);
      exp_t e;
      e.data = d;
      e.idx  = idx;
      e.fd   = is_scan && (idx == 6'd63);
      e.due  = eff_cnt + 3;
      sb_q.push_back(e);
   endfunction

   // One cycle of stimulus; exp_d is the hand-computed bit for external requests.
   task automatic step(input logic se, input logic sv, input logic [5:0] s,
                       input logic [LANE_W-1:0] exp_d, input logic st);
      logic [63:0] d;
      @(posedge clk);
      #1;
      scan_en   = se;
      sel_valid = sv;
      sel       = s;
      stall     = st;
      if (!st) begin
         if (se) begin
            d = din >> m_scan;
            push(m_scan, 1'b1, d[LANE_W-1:0]);
            m_scan = m_scan + 6'd1;
         end else begin
            m_scan = '0;
            if (sv) push(s, 1'b0, exp_d);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'd0, '0, 1'b0);
   endtask

   // Monitor
   initial begin
      exp_t              e;
      logic [LANE_W-1:0] p_dout = '0;
      logic              p_v = 1'b0;
      logic [5:0]        p_idx = '0;
      logic              p_fd = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) continue;
         if (edge_stalled) begin
            chk("stall_hold_dout", dout, p_dout);
            chk("stall_hold_valid", dout_valid, p_v);
            chk("stall_hold_idx", dout_idx, p_idx);
            chk("stall_hold_frame_done", frame_done, p_fd);
         end else if (dout_valid) begin
            if (sb_q.size() == 0) begin
               chk("spurious_dout_valid", dout_valid, 1'b0);
            end else begin
               e = sb_q.pop_front();
               $display("out idx=%0d data=%0h frame_done=%0b", dout_idx, dout, frame_done);
               chk("dout_idx", dout_idx, e.idx);
               chk("dout", dout, e.data);
               chk("frame_done", frame_done, e.fd);
               chk("latency", eff_cnt, e.due);
            end
         end else begin
            chk("frame_done_without_valid", frame_done, 1'b0);
         end
         while (sb_q.size() > 0 && sb_q[0].due < eff_cnt) begin
            e = sb_q.pop_front();
            chk("missing_output_idx", 64, e.idx);
         end
         p_dout = dout;
         p_v    = dout_valid;
         p_idx  = dout_idx;
         p_fd   = frame_done;
      end
   end

   // Driver
   initial begin
      #1;
      chk("reset_dout", dout, 0);
      chk("reset_dout_valid", dout_valid, 0);
      chk("reset_dout_idx", dout_idx, 0);
      chk("reset_frame_done", frame_done, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Single external request
      din = 64'd1 << 37;
      step(1'b0, 1'b1, 6'd37, 1'b1, 1'b0);
      idle(6);

      // Back-to-back external requests
      din = 64'hA5A5_0F0F_FFFF_0000;
      step(1'b0, 1'b1, 6'd0,  1'b0, 1'b0);
      step(1'b0, 1'b1, 6'd21, 1'b1, 1'b0);
      step(1'b0, 1'b1, 6'd42, 1'b1, 1'b0);
      step(1'b0, 1'b1, 6'd63, 1'b1, 1'b0);
      step(1'b0, 1'b1, 6'd4,  1'b0, 1'b0);
      idle(6);

      // Auto-scan across two frames
      din = 64'h8000_0000_0000_0001;
      for (int i = 0; i < 130; i++) step(1'b1, 1'b0, 6'd0, '0, 1'b0);
      idle(5);

      // Stall mid-scan after lane 10 is issued
      for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 6'd0, '0, 1'b0);
      for (int i = 0; i < 5; i++)  step(1'b1, 1'b0, 6'd0, '0, 1'b1);
      for (int i = 0; i < 5; i++)  step(1'b1, 1'b0, 6'd0, '0, 1'b0);
      idle(5);

      // External request during stall is lost
      step(1'b0, 1'b1, 6'd0, 1'b1, 1'b1);
      idle(5);

      // sel_valid ignored while scanning; scan restarts at lane 0
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 6'd5, '0, 1'b0);
      idle(1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'd0, '0, 1'b0);
      idle(5);

      // Asynchronous reset with entries in flight
      din = '1;
      step(1'b0, 1'b1, 6'd63, 1'b1, 1'b0);
      idle(5);
      step(1'b0, 1'b1, 6'd1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 6'd2, 1'b1, 1'b0);
      step(1'b0, 1'b1, 6'd3, 1'b1, 1'b0);
      #1;
      rst_n     = 1'b0;
      sel_valid = 1'b0;
      sb_q.delete();
      m_scan = '0;
      #1;
      chk("async_reset_dout", dout, 0);
      chk("async_reset_dout_valid", dout_valid, 0);
      chk("async_reset_dout_idx", dout_idx, 0);
      chk("async_reset_frame_done", frame_done, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      idle(6);

      // Recovery after reset
      din = 64'd1 << 37;
      step(1'b0, 1'b1, 6'd37, 1'b1, 1'b0);
      idle(6);

      chk("scoreboard_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
